sram_controller: RTL and testbench



---
 rtl/sram_controller.sv | 104 ++++++++++
 tb/tb_sram_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as
// two half-word phases (low then high), freezing the pipeline through ready.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] word_q;
    logic [31:0] data_q;
    logic [31:0] off_in;
    logic        req;
    logic        phase_end;
    logic        unused_off_bits;

    assign req             = wr_en | rd_en;
    assign off_in          = address - BASE_ADDR;
    assign unused_off_bits = ^{off_in[31:19], off_in[1:0]};
    assign phase_end       = ((state == S_LOW) || (state == S_HIGH)) && (cnt == WAIT_LAST);
    assign state_dbg       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            word_q    <= 17'd0;
            data_q    <= 32'd0;
            read_data <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_wr  <= wr_en;
                        word_q <= off_in[18:2];
                        data_q <= write_data;
                        cnt    <= 4'd0;
                        state  <= S_LOW;
                    end
                end
                S_LOW, S_HIGH: begin
                    if (phase_end) begin
                        cnt <= 4'd0;
                        if (!op_wr) begin
                            if (state == S_LOW) read_data[15:0]  <= sram_dq_in;
                            else                read_data[31:16] <= sram_dq_in;
                        end
                        state <= (state == S_LOW) ? S_HIGH : S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake: ready=1 means the pipeline may advance on the next edge. In IDLE
    // it is ~request (combinational), 0 throughout LOW/HIGH, and 1 only in DONE.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = 18'd0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'd0;
        case (state)
            S_IDLE: ready = ~req;
            S_DONE: ready = 1'b1;
            S_LOW, S_HIGH: begin
                sram_addr  = {word_q, state == S_HIGH};
                sram_we_n  = ~op_wr;
                sram_dq_oe = op_wr;
                if (op_wr)
                    sram_dq_out = (state == S_HIGH) ? data_q[31:16] : data_q[15:0];
            end
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: W=1 instance against a half-word SRAM model, plus
// W=0 and W=3 instances against an address-derived data pattern for timing.
module tb_sram_controller;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;

    logic [31:0] read_data_1, read_data_0, read_data_3;
    logic        ready_1, ready_0, ready_3;
    logic [17:0] addr_1, addr_0, addr_3;
    logic        we_n_1, we_n_0, we_n_3;
    logic [15:0] dq_out_1, dq_out_0, dq_out_3;
    logic        oe_1, oe_0, oe_3;
    logic [15:0] dq_in_1, dq_in_0, dq_in_3;
    logic [1:0]  state_1, state_0, state_3;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow[int];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data_1), .ready(ready_1),
        .sram_addr(addr_1), .sram_we_n(we_n_1), .sram_dq_out(dq_out_1),
        .sram_dq_oe(oe_1), .sram_dq_in(dq_in_1), .state_dbg(state_1));

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data_0), .ready(ready_0),
        .sram_addr(addr_0), .sram_we_n(we_n_0), .sram_dq_out(dq_out_0),
        .sram_dq_oe(oe_0), .sram_dq_in(dq_in_0), .state_dbg(state_0));

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data_3), .ready(ready_3),
        .sram_addr(addr_3), .sram_we_n(we_n_3), .sram_dq_out(dq_out_3),
        .sram_dq_oe(oe_3), .sram_dq_in(dq_in_3), .state_dbg(state_3));

    // Half-word SRAM model for the W=1 instance; others see address ^ 0x5A5A.
    logic [15:0] sram_mem [0:1023];
    always @(posedge clk) if (!we_n_1) sram_mem[addr_1[9:0]] <= dq_out_1;
    assign dq_in_1 = sram_mem[addr_1[9:0]];
    assign dq_in_0 = addr_0[15:0] ^ 16'h5A5A;
    assign dq_in_3 = addr_3[15:0] ^ 16'h5A5A;

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        #2;
        vectors++; if (ready_1 !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready_1); end
        vectors++; if (we_n_1 !== 1'b1 || oe_1 !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got we_n=%b oe=%b want 1/0", we_n_1, oe_1); end
        vectors++; if (addr_1 !== 18'd0 || dq_out_1 !== 16'd0) begin miscompares++; $display("FAIL reset_bus: got addr=%h dq=%h want 0/0", addr_1, dq_out_1); end
        vectors++; if (read_data_1 !== 32'd0) begin miscompares++; $display("FAIL reset_read_data: got %h want 0", read_data_1); end
        vectors++; if (state_1 !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state_1, S_IDLE); end
        rd_en = 1'b1; #1;
        vectors++; if (ready_1 !== 1'b0) begin miscompares++; $display("FAIL reset_ready_req: got %b want 0", ready_1); end
        rd_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // One access on the W=1 instance; request applied in cycle 0, dropped in cycle drop_at.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input int drop_at, input string name);
        logic [31:0] off;
        logic [17:0] ea;
        logic [31:0] want;
        int key;
        off = a - 32'd1024;
        key = int'(off[18:2]);
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        vectors++; if (ready_1 !== 1'b0 || state_1 !== S_IDLE) begin miscompares++; $display("FAIL %s c0: got ready=%b state=%0d want 0/%0d", name, ready_1, state_1, S_IDLE); end
        if (!w) exp_q.push_back(shadow.exists(key) ? shadow[key] : 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == drop_at) begin
                wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
            end
            #1;
            if (c <= 4) begin
                ea = {off[18:2], c > 2};
                vectors++; if (addr_1 !== ea || state_1 !== ((c <= 2) ? S_LOW : S_HIGH)) begin miscompares++; $display("FAIL %s c%0d addr: got %h st=%0d want %h", name, c, addr_1, state_1, ea); end
                vectors++; if (ready_1 !== 1'b0 || we_n_1 !== ~w || oe_1 !== w) begin miscompares++; $display("FAIL %s c%0d ctl: got rdy=%b we_n=%b oe=%b want 0/%b/%b", name, c, ready_1, we_n_1, oe_1, ~w, w); end
                if (w) begin
                    vectors++; if (dq_out_1 !== ((c <= 2) ? d[15:0] : d[31:16])) begin miscompares++; $display("FAIL %s c%0d dq_out: got %h want %h", name, c, dq_out_1, (c <= 2) ? d[15:0] : d[31:16]); end
                end
            end else begin
                vectors++; if (ready_1 !== 1'b1 || state_1 !== S_DONE || we_n_1 !== 1'b1 || oe_1 !== 1'b0) begin miscompares++; $display("FAIL %s c5 done: got rdy=%b st=%0d we_n=%b oe=%b want 1/%0d/1/0", name, ready_1, state_1, we_n_1, oe_1, S_DONE); end
                if (!w) begin
                    want = exp_q.pop_front();
                    last_rd = want;
                    vectors++; if (read_data_1 !== want) begin miscompares++; $display("FAIL %s read_data: got %h want %h", name, read_data_1, want); end
                end
                wr_en = 1'b0; rd_en = 1'b0;
            end
        end
        if (w) shadow[key] = d;
    endtask

    task automatic test_write_read;
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1, "wr_1024");
        run_access(1'b0, 1'b1, 32'd1024, 32'd0, 1, "rd_1024");
    endtask

    task automatic test_addr_map;
        run_access(1'b1, 1'b0, 32'd1024 + 32'h40, 32'h22221111, 1, "wr_0x40");
        run_access(1'b0, 1'b1, 32'd1024 + 32'h40, 32'd0, 1, "rd_0x40");
        run_access(1'b0, 1'b1, 32'd1025, 32'd0, 1, "rd_1025");
    endtask

    task automatic test_both_enables;
        run_access(1'b1, 1'b1, 32'd1024 + 32'h10, 32'hCAFEF00D, 2, "both_en");
        run_access(1'b0, 1'b1, 32'd1024 + 32'h10, 32'd0, 1, "rd_both");
    endtask

    task automatic test_idle;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            vectors++; if (ready_1 !== 1'b1 || we_n_1 !== 1'b1 || oe_1 !== 1'b0) begin miscompares++; $display("FAIL idle c%0d: got rdy=%b we_n=%b oe=%b want 1/1/0", c, ready_1, we_n_1, oe_1); end
            vectors++; if (read_data_1 !== last_rd) begin miscompares++; $display("FAIL idle_hold c%0d: got %h want %h", c, read_data_1, last_rd); end
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024 + 32'h8; write_data = 32'h12345678;
        @(posedge clk); #1 wr_en = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        vectors++; if (state_1 !== S_HIGH || we_n_1 !== 1'b0) begin miscompares++; $display("FAIL mid_pre: got st=%0d we_n=%b want %0d/0", state_1, we_n_1, S_HIGH); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (we_n_1 !== 1'b1 || oe_1 !== 1'b0 || state_1 !== S_IDLE) begin miscompares++; $display("FAIL mid_rst: got we_n=%b oe=%b st=%0d want 1/0/%0d", we_n_1, oe_1, state_1, S_IDLE); end
        vectors++; if (read_data_1 !== 32'd0 || ready_1 !== 1'b1 || addr_1 !== 18'd0) begin miscompares++; $display("FAIL mid_rst_data: got rd=%h rdy=%b addr=%h want 0/1/0", read_data_1, ready_1, addr_1); end
        #1 rst = 1'b0;
        run_access(1'b0, 1'b1, 32'd1024, 32'd0, 1, "rd_after_rst");
    endtask

    task automatic test_back_to_back_w0;
        logic [31:0] want;
        @(posedge clk); #1 rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024 + 32'h100;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            #1;
            if (c % 4 == 0) exp_q.push_back({16'h5ADB, 16'h5ADA});
            vectors++; if (ready_0 !== (c % 4 == 3)) begin miscompares++; $display("FAIL w0_ready c%0d: got %b want %b", c, ready_0, c % 4 == 3); end
            if (c % 4 == 3) begin
                want = exp_q.pop_front();
                vectors++; if (read_data_0 !== want) begin miscompares++; $display("FAIL w0_read c%0d: got %h want %h", c, read_data_0, want); end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wait3;
        int got_c;
        logic [31:0] want;
        got_c = -1;
        @(posedge clk); #1 rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024 + 32'h200;
        exp_q.push_back({16'h5B5B, 16'h5B5A});
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) rd_en = 1'b0;
            #1;
            if (ready_3 === 1'b1 && got_c < 0) begin
                got_c = c;
                want = exp_q.pop_front();
                vectors++; if (read_data_3 !== want) begin miscompares++; $display("FAIL w3_read: got %h want %h", read_data_3, want); end
            end
        end
        vectors++; if (got_c != 9) begin miscompares++; $display("FAIL w3_ready_cycle: got %0d want 9", got_c); end
        if (got_c < 0) exp_q.delete();
    endtask

    initial begin
        last_rd = 32'd0;
        test_reset();
        test_write_read();
        test_addr_map();
        test_both_enables();
        test_idle();
        test_reset_mid();
        test_back_to_back_w0();
        test_wait3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
